life_engine: RTL
================

# life_engine

Parametrised Game of Life engine: holds a ROWS×COLS cell grid and evolves it under rule B3/S23, one generation per `step` pulse or free-running at a programmable rate. The grid can be loaded from an external seed or filled from an internal 32-bit LFSR. It reports the generation count, still-life detection and extinction. It replaces the fixed 8×8 seed/evolve/select top in the display path; `grid` drives the LED matrix driver directly.

## Interface
- `ROWS`, 8, grid rows
- `COLS`, 8, grid columns; N = ROWS*COLS
- `GEN_W`, 16, generation counter width
- `RUN_DIV`, 1, clock cycles per generation in run mode (≥1)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `seed_load`  in  1  pulse: load `seed` into grid
- `seed`  in  N  seed pattern
- `rand_start`  in  1  pulse: fill grid from LFSR
- `lfsr_seed`  in  32  LFSR initial value (0 replaced by 32'h1)
- `step`  in  1  pulse: one generation (IDLE only)
- `run`  in  1  level: free-run generations
- `wrap`  in  1  1 = toroidal edges, 0 = out-of-grid cells dead
- `grid`  out  N  current grid; bit r*COLS+c = cell (r,c), row 0 at LSB
- `gen_count`  out  GEN_W  generations committed since last load, saturating
- `busy`  out  1  high in RANDOM
- `stable`  out  1  last attempted generation left grid unchanged
- `extinct`  out  1  grid == 0 (combinational from grid register)

## Operation
- States: IDLE, RANDOM, RUN, HALT.
- Priority per cycle: reset > seed_load > rand_start > step/run.
- seed_load (any state): grid←seed, gen_count←0, stable←0, LFSR untouched, →IDLE.
- rand_start (IDLE/RUN/HALT): lfsr←lfsr_seed (or 1), bit counter←0, gen_count←0, stable←0, →RANDOM. Ignored while in RANDOM.
- RANDOM: each cycle grid←{grid[N-2:0], lfsr[0]}; lfsr←lfsr[0] ? (lfsr>>1)^32'h80200003 : lfsr>>1; after N cycles →IDLE. step/run ignored.
- IDLE: step → commit one generation. run=1 → RUN, tick counter←0.
- RUN: tick counter counts 0..RUN_DIV-1; commit at RUN_DIV-1 and wrap to 0. run=0 → IDLE next cycle, counter cleared. step ignored.
- Commit: next = rule applied to all cells (neighbour count 0–8; wrap selects edge handling). If next == grid: grid unchanged, gen_count unchanged, stable←1, →HALT. Otherwise grid←next, gen_count+1 (saturating at all-ones).
- HALT: holds until seed_load or rand_start. step/run ignored.

## Timing
- Reset values: grid=0, gen_count=0, stable=0, busy=0, lfsr=1, state IDLE, tick counter 0. extinct therefore reads 1.
- seed_load/step: result visible the cycle after the input is sampled (1-cycle latency).
- rand_start: busy high for exactly N cycles starting the next cycle; grid final at the edge where busy falls.
- Run: first commit RUN_DIV cycles after the edge entering RUN, then every RUN_DIV cycles.
- Reset mid-RANDOM or mid-RUN: full reset values next cycle. No partial state survives.
- Simultaneous seed_load and rand_start: seed_load wins, rand_start dropped.

## Structure
- `life_pkg`: state enum, LFSR mask constant 32'h80200003, LFSR nonzero default.
- Sub-module `life_next` (combinational, parameters ROWS/COLS; inputs grid and wrap; output next grid). Instantiated once.
- Top `life_engine`: FSM, LFSR, tick and bit counters, gen_count, stable/extinct.

## Test plan
- Blinker, 8×8, wrap=0: seed 64'h0000_0000_1C00_0000, step → grid 64'h0000_0008_0808_0000, gen_count=1. Second step → original pattern, gen_count=2.
- Edge wrap: seed bits {24,25,31}, wrap=1, step → 64'h0000_0001_0101_0000. Same seed with wrap=0, step → grid 0, extinct=1, gen_count=1. Next step → stable=1, HALT, gen_count stays 1.
- Still life: 2×2 block at bits {0,1,8,9}, step → grid unchanged, stable=1, gen_count=0, subsequent step/run ignored until seed_load.
- Run, RUN_DIV=4, blinker seed, run held 8 cycles → commits at cycles 4 and 8, gen_count=2, grid back to horizontal. run low → no further commits.
- Random: lfsr_seed=0, rand_start → busy high 64 cycles. Then grid[63]=1 (first bit inserted from lfsr=1) and matches a reference model of the Galois LFSR.
- Reset asserted at cycle 10 of RANDOM → next cycle grid=0, busy=0, gen_count=0, IDLE. seed_load with rand_start in the same cycle → grid=seed, busy stays 0.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life engine: FSM states and the
// Galois LFSR used to fill the grid with a pseudo-random pattern.
package life_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RANDOM = 2'd1,
        S_RUN    = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT = 32'h0000_0001;

    // One right-shift step of the Galois LFSR; feedback taps applied when bit 0 falls out.
    function automatic logic [31:0] lfsr_advance(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/life_next.sv
// Combinational B3/S23 next-generation computation for a ROWS x COLS grid.
// Edge neighbours either wrap toroidally or read as dead, selected by i_wrap.
module life_next #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic [ROWS*COLS-1:0] i_grid,
    input  logic                 i_wrap,
    output logic [ROWS*COLS-1:0] o_next
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS*COLS; gi++) begin : g_cell
            localparam int R = gi / COLS;
            localparam int C = gi % COLS;
            logic [8:0] w_nb;
            logic [3:0] w_cnt;

            // 3x3 window, gj = 4 is the cell itself and never counts.
            for (gj = 0; gj < 9; gj++) begin : g_nb
                localparam int  RR     = R + gj / 3 - 1;
                localparam int  CC     = C + gj % 3 - 1;
                localparam bit  INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                localparam int  IDX    = ((RR + ROWS) % ROWS) * COLS + ((CC + COLS) % COLS);
                if (gj == 4) begin : g_self
                    assign w_nb[gj] = 1'b0;
                end else if (INSIDE) begin : g_in
                    assign w_nb[gj] = i_grid[IDX];
                end else begin : g_edge
                    assign w_nb[gj] = i_wrap & i_grid[IDX];
                end
            end

            assign w_cnt     = 4'($countones(w_nb));
            assign o_next[gi] = (w_cnt == 4'd3) | (i_grid[gi] & (w_cnt == 4'd2));
        end
    endgenerate

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: grid register, seed/LFSR loading, single-step and
// free-running evolution with still-life halt and extinction flag.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int GEN_W   = 16,
    parameter int RUN_DIV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seed_load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 rand_start,
    input  logic [31:0]          lfsr_seed,
    input  logic                 step,
    input  logic                 run,
    input  logic                 wrap,
    output logic [ROWS*COLS-1:0] grid,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 busy,
    output logic                 stable,
    output logic                 extinct
);

    localparam int N      = ROWS * COLS;
    localparam int TICK_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int BIT_W  = $clog2(N + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RUN_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);

    state_t             r_state;
    logic [N-1:0]       r_grid;
    logic [GEN_W-1:0]   r_gen;
    logic               r_stable;
    logic [31:0]        r_lfsr;
    logic [TICK_W-1:0]  r_tick;
    logic [BIT_W-1:0]   r_bit;

    logic [N-1:0]       w_next;
    logic               w_rand_go;
    logic               w_commit;

    life_next #(.ROWS(ROWS), .COLS(COLS)) u_next (
        .i_grid (r_grid),
        .i_wrap (wrap),
        .o_next (w_next)
    );

    // rand_start is dropped while a fill is already in progress.
    assign w_rand_go = rand_start && (r_state != S_RANDOM);
    assign w_commit  = ((r_state == S_IDLE) && step) ||
                       ((r_state == S_RUN) && run && (r_tick == TICK_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grid   <= '0;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_lfsr   <= LFSR_DEFAULT;
            r_tick   <= '0;
            r_bit    <= '0;
        end else if (seed_load) begin
            r_state  <= S_IDLE;
            r_grid   <= seed;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_tick   <= '0;
        end else if (w_rand_go) begin
            r_state  <= S_RANDOM;
            r_lfsr   <= (lfsr_seed == 32'd0) ? LFSR_DEFAULT : lfsr_seed;
            r_bit    <= '0;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_tick   <= '0;
        end else if (w_commit) begin
            r_tick <= '0;
            // An unchanged grid can never change again, so park in HALT.
            if (w_next == r_grid) begin
                r_stable <= 1'b1;
                r_state  <= S_HALT;
            end else begin
                r_grid   <= w_next;
                r_stable <= 1'b0;
                if (!(&r_gen))
                    r_gen <= r_gen + 1'b1;
            end
        end else begin
            case (r_state)
                S_RANDOM: begin
                    r_grid <= {r_grid[N-2:0], r_lfsr[0]};
                    r_lfsr <= lfsr_advance(r_lfsr);
                    r_bit  <= r_bit + 1'b1;
                    if (r_bit == BIT_LAST)
                        r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_RUN;
                        r_tick  <= '0;
                    end
                end
                S_RUN: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grid      = r_grid;
    assign gen_count = r_gen;
    assign stable    = r_stable;
    assign busy      = (r_state == S_RANDOM);
    assign extinct   = (r_grid == '0);

endmodule
